nand_async_seq: RTL and testbench

NAND_ASYNC_SEQ -- requirements
Module: nand_async_seq

---
 rtl/nand_async_pkg.sv | 39 +++
 rtl/nand_async_seq_if.sv | 24 ++
 rtl/nand_async_timer.sv | 25 ++
 rtl/nand_async_seq.sv | 201 ++++++++++++++++++++
 tb/tb_nand_async_seq.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nand_async_pkg.sv
// Shared types and constants for the async NAND beat sequencer.
// Op codes, FSM states and default strobe timing.
package nand_async_pkg;

  typedef enum logic [1:0] {
    OP_CMD  = 2'd0,
    OP_ADDR = 2'd1,
    OP_WR   = 2'd2,
    OP_RD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_CE_GAP
  } state_e;

  localparam int unsigned T_WP_DEF = 3;
  localparam int unsigned T_WH_DEF = 2;
  localparam int unsigned T_CS_DEF = 2;

  typedef struct packed {
    op_e        op;
    logic [2:0] chip;
    logic       last;
  } beat_t;

  function automatic logic [7:0] cen_of(
    input logic [2:0] chip
  );
    logic [7:0] v;
    v = 8'hFF;
    v[chip] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/nand_async_seq_if.sv
// Request/response handshake bundle of the sequencer.
// master drives requests, slave returns ready and read bytes.
interface nand_async_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic [2:0] req_chip;
  logic       req_last;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  modport master (
    output req_valid, req_op, req_data,
    output req_chip, req_last,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_data,
    input  req_chip, req_last,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/nand_async_timer.sv
// Loadable 4-bit down-counter timing one strobe phase.
// A phase loaded with N spans N cycles; done marks the last.
module nand_async_timer (
  input  logic       v_clk0,
  input  logic       v_rstn0,
  input  logic       load,
  input  logic [3:0] value,
  output logic       done
);

  logic [3:0] cnt;

  // count down to zero, reload on request
  always_ff @(posedge v_clk0) begin
    if (!v_rstn0)
      cnt <= 4'd0;
    else if (load)
      cnt <= value;
    else if (cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  assign done = (cnt == 4'd1);

endmodule

// File: rtl/nand_async_seq.sv
// Async-mode NAND beat sequencer: CE#/CLE/ALE setup,
// WE#/RE# low and high phases, read capture, CE# hold.
module nand_async_seq
  import nand_async_pkg::*;
#(
  parameter int unsigned T_WP = T_WP_DEF,
  parameter int unsigned T_WH = T_WH_DEF,
  parameter int unsigned T_CS = T_CS_DEF
) (
  input  logic       v_clk0,
  input  logic       v_rstn0,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  input  logic [2:0] req_chip,
  input  logic       req_last,
  input  logic       cfg_wp_n,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       v_ctrl_cle,
  output logic       v_ctrl_ale,
  output logic       v_ctrl_wrn,
  output logic       v_ctrl_wpn,
  output logic       v_ctrl_wen,
  output logic       v_ctrl_wen_sel,
  output logic       v_dq_oe_n,
  output logic       v_dqs_oe_n,
  output logic       v_dqs_rst_n,
  output logic [7:0] v_ctrl_cen,
  output logic [7:0] v_wr_data_rise,
  output logic [7:0] v_wr_data_fall,
  input  logic [7:0] v_rd_data_comb
);

  localparam logic [3:0] CS4 = 4'(T_CS);
  localparam logic [3:0] WP4 = 4'(T_WP);
  localparam logic [3:0] WH4 = 4'(T_WH);

  state_e     state;
  beat_t      beat;
  logic       held;
  logic [2:0] held_chip;
  logic       idle_rdy;
  logic       tload;
  logic [3:0] tval;
  logic       done;
  logic       accept;
  logic       req_gap;
  op_e        rop;

  assign rop     = op_e'(req_op);
  assign accept  = req_valid & req_ready;
  assign req_gap = held & (req_chip != held_chip);

  assign req_ready = idle_rdy
                   | ((state == S_HIGH) & done & ~beat.last);

  assign v_ctrl_wen_sel = 1'b1;
  assign v_dqs_oe_n     = 1'b1;
  assign v_dqs_rst_n    = 1'b1;

  nand_async_timer u_timer (
    .v_clk0  (v_clk0),
    .v_rstn0 (v_rstn0),
    .load    (tload),
    .value   (tval),
    .done    (done)
  );

  // phase length to load on each state entry
  always_comb begin
    tload = 1'b0;
    tval  = CS4;
    if (accept) begin
      tload = ~req_gap;
      tval  = CS4;
    end else begin
      unique case (state)
        S_SETUP: begin
          tload = done;
          tval  = WP4;
        end
        S_LOW: begin
          tload = done;
          tval  = WH4;
        end
        S_CE_GAP: begin
          tload = 1'b1;
          tval  = CS4;
        end
        default: begin
          tload = 1'b0;
          tval  = CS4;
        end
      endcase
    end
  end

  // write-protect level follows config one cycle late
  always_ff @(posedge v_clk0) begin
    if (!v_rstn0)
      v_ctrl_wpn <= 1'b0;
    else
      v_ctrl_wpn <= cfg_wp_n;
  end

  // beat sequencer with registered PHY controls
  always_ff @(posedge v_clk0) begin
    if (!v_rstn0) begin
      state          <= S_IDLE;
      beat           <= '{op: OP_CMD, chip: 3'd0, last: 1'b0};
      held           <= 1'b0;
      held_chip      <= 3'd0;
      idle_rdy       <= 1'b0;
      v_ctrl_cen     <= 8'hFF;
      v_ctrl_cle     <= 1'b0;
      v_ctrl_ale     <= 1'b0;
      v_ctrl_wen     <= 1'b1;
      v_ctrl_wrn     <= 1'b1;
      v_dq_oe_n      <= 1'b1;
      v_wr_data_rise <= 8'd0;
      v_wr_data_fall <= 8'd0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        beat <= '{op: rop, chip: req_chip, last: req_last};
        idle_rdy       <= 1'b0;
        v_wr_data_rise <= req_data;
        v_wr_data_fall <= req_data;
        if (req_gap) begin
          state      <= S_CE_GAP;
          held       <= 1'b0;
          v_ctrl_cen <= 8'hFF;
          v_ctrl_cle <= 1'b0;
          v_ctrl_ale <= 1'b0;
          v_dq_oe_n  <= 1'b1;
        end else begin
          state      <= S_SETUP;
          held       <= 1'b1;
          held_chip  <= req_chip;
          v_ctrl_cen <= cen_of(req_chip);
          v_ctrl_cle <= (rop == OP_CMD);
          v_ctrl_ale <= (rop == OP_ADDR);
          v_dq_oe_n  <= (rop == OP_RD);
        end
      end else begin
        unique case (state)
          S_SETUP: begin
            if (done) begin
              state <= S_LOW;
              if (beat.op == OP_RD)
                v_ctrl_wrn <= 1'b0;
              else
                v_ctrl_wen <= 1'b0;
            end
          end
          S_LOW: begin
            if (done) begin
              state      <= S_HIGH;
              v_ctrl_wen <= 1'b1;
              v_ctrl_wrn <= 1'b1;
              if (beat.op == OP_RD) begin
                rsp_data  <= v_rd_data_comb;
                rsp_valid <= 1'b1;
              end
            end
          end
          S_HIGH: begin
            if (done) begin
              state    <= S_IDLE;
              idle_rdy <= 1'b1;
              if (beat.last) begin
                held       <= 1'b0;
                v_ctrl_cen <= 8'hFF;
                v_ctrl_cle <= 1'b0;
                v_ctrl_ale <= 1'b0;
                v_dq_oe_n  <= 1'b1;
              end
            end
          end
          S_CE_GAP: begin
            state      <= S_SETUP;
            held       <= 1'b1;
            held_chip  <= beat.chip;
            v_ctrl_cen <= cen_of(beat.chip);
            v_ctrl_cle <= (beat.op == OP_CMD);
            v_ctrl_ale <= (beat.op == OP_ADDR);
            v_dq_oe_n  <= (beat.op == OP_RD);
          end
          default: begin
            idle_rdy <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nand_async_seq.sv
// Randomised bench for nand_async_seq against a
// timeline model of each beat's phases.
module tb_nand_async_seq;
  import nand_async_pkg::*;

  localparam int TCS = 2;
  localparam int TWP = 3;
  localparam int TWH = 2;
  localparam int TOT = TCS + TWP + TWH;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [2:0] chip;
    bit         last;
  } beat_s;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nand_async_seq_if bus();

  logic       cfg_wp_n = 1'b0;
  logic [7:0] rd_comb = 8'd0;
  logic       cle, ale, wrn, wpn, wen, wen_sel;
  logic       dq_oe_n, dqs_oe_n, dqs_rst_n;
  logic [7:0] cen, wr_rise, wr_fall;

  nand_async_seq #(
    .T_WP(TWP), .T_WH(TWH), .T_CS(TCS)
  ) dut (
    .v_clk0         (clk),
    .v_rstn0        (rstn),
    .req_valid      (bus.req_valid),
    .req_ready      (bus.req_ready),
    .req_op         (bus.req_op),
    .req_data       (bus.req_data),
    .req_chip       (bus.req_chip),
    .req_last       (bus.req_last),
    .cfg_wp_n       (cfg_wp_n),
    .rsp_valid      (bus.rsp_valid),
    .rsp_data       (bus.rsp_data),
    .v_ctrl_cle     (cle),
    .v_ctrl_ale     (ale),
    .v_ctrl_wrn     (wrn),
    .v_ctrl_wpn     (wpn),
    .v_ctrl_wen     (wen),
    .v_ctrl_wen_sel (wen_sel),
    .v_dq_oe_n      (dq_oe_n),
    .v_dqs_oe_n     (dqs_oe_n),
    .v_dqs_rst_n    (dqs_rst_n),
    .v_ctrl_cen     (cen),
    .v_wr_data_rise (wr_rise),
    .v_wr_data_fall (wr_fall),
    .v_rd_data_comb (rd_comb)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // model state
  bit         active = 0;
  int         t0 = 0;
  beat_s      cur;
  bit         held = 0;
  logic [2:0] held_chip = 3'd0;
  logic [7:0] exp_rsp = 8'd0;
  logic [7:0] rd_sample = 8'd0;
  logic       exp_wpn = 1'b0;
  bit         m_ready = 0;
  bit         pending = 0;
  bit         directed = 1;
  bit         quiet = 0;
  logic [2:0] fav_chip = 3'd1;
  beat_s      plan[$];

  task automatic check_eq(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] onehot_low(
    input logic [2:0] c
  );
    logic [7:0] v;
    v = 8'hFF;
    v[c] = 1'b0;
    return v;
  endfunction

  task automatic check_cycle();
    int o;
    bit in_low, rv;
    o = cyc - t0;
    in_low = active && o >= TCS && o < TCS + TWP;
    m_ready = !active || (o == TOT - 1 && !cur.last);
    rv = active && cur.op == 2'd3 && o == TCS + TWP;
    if (rv) exp_rsp = rd_sample;
    check_eq("req_ready", bus.req_ready, m_ready);
    check_eq("wen", wen, !(in_low && cur.op != 2'd3));
    check_eq("wrn", wrn, !(in_low && cur.op == 2'd3));
    check_eq("rsp_valid", bus.rsp_valid, rv);
    check_eq("rsp_data", bus.rsp_data, exp_rsp);
    check_eq("wpn", wpn, exp_wpn);
    check_eq("wen_sel", wen_sel, 1);
    check_eq("dqs_oe_n", dqs_oe_n, 1);
    check_eq("dqs_rst_n", dqs_rst_n, 1);
    if (active && o >= 0) begin
      check_eq("cen", cen, onehot_low(cur.chip));
      check_eq("cle", cle, cur.op == 2'd0);
      check_eq("ale", ale, cur.op == 2'd1);
      check_eq("dq_oe_n", dq_oe_n, cur.op == 2'd3);
      check_eq("wr_rise", wr_rise, cur.data);
      check_eq("wr_fall", wr_fall, cur.data);
    end else if (active) begin
      check_eq("cen_gap", cen, 8'hFF);
    end else if (held) begin
      check_eq("cen_held", cen, onehot_low(held_chip));
    end else begin
      check_eq("cen_idle", cen, 8'hFF);
      check_eq("cle_idle", cle, 0);
      check_eq("ale_idle", ale, 0);
      check_eq("dq_oe_idle", dq_oe_n, 1);
    end
  endtask

  task automatic drive();
    beat_s b;
    if ($urandom_range(0, 3) == 0) cfg_wp_n = ~cfg_wp_n;
    rd_comb = directed ? 8'hE0 : 8'($urandom);
    if (pending) return;
    if (plan.size() > 0) begin
      b = plan.pop_front();
    end else if (!quiet && $urandom_range(0, 9) < 7) begin
      if ($urandom_range(0, 3) == 0)
        fav_chip = 3'($urandom_range(0, 7));
      b.op   = 2'($urandom_range(0, 3));
      b.data = 8'($urandom);
      b.chip = fav_chip;
      b.last = ($urandom_range(0, 2) == 0);
    end else begin
      bus.req_valid = 1'b0;
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = b.op;
    bus.req_data  = b.data;
    bus.req_chip  = b.chip;
    bus.req_last  = b.last;
  endtask

  task automatic step();
    int o;
    bit acc, gap, h;
    logic [2:0] hc;
    o = cyc - t0;
    acc = bus.req_valid && m_ready;
    pending = bus.req_valid && !acc;
    if (active && cur.op == 2'd3 && o == TCS + TWP - 1)
      rd_sample = rd_comb;
    exp_wpn = cfg_wp_n;
    if (acc) begin
      h  = active ? 1'b1 : held;
      hc = active ? cur.chip : held_chip;
      gap = h && (bus.req_chip != hc);
      cur.op   = bus.req_op;
      cur.data = bus.req_data;
      cur.chip = bus.req_chip;
      cur.last = bus.req_last;
      active = 1;
      t0 = cyc + 1 + int'(gap);
    end else if (active && o == TOT - 1) begin
      active = 0;
      held = !cur.last;
      held_chip = cur.chip;
    end
    cyc++;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_cycle();
    drive();
    step();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_cen", cen, 8'hFF);
    check_eq("rst_cle", cle, 0);
    check_eq("rst_ale", ale, 0);
    check_eq("rst_wen", wen, 1);
    check_eq("rst_wrn", wrn, 1);
    check_eq("rst_wpn", wpn, 0);
    check_eq("rst_dq_oe", dq_oe_n, 1);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_data", bus.rsp_data, 0);
    check_eq("rst_ready", bus.req_ready, 0);
  endtask

  task automatic release_reset();
    rstn = 1'b1;
    active = 0;
    held = 0;
    pending = 0;
    exp_rsp = 8'd0;
    exp_wpn = cfg_wp_n;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    bit hit;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_data  = 8'd0;
    bus.req_chip  = 3'd0;
    bus.req_last  = 1'b0;
    cur = '{2'd0, 8'd0, 3'd0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    cfg_wp_n = 1'b1;
    check_reset_outputs();
    release_reset();

    plan.push_back('{2'd0, 8'h70, 3'd2, 1'b0});
    plan.push_back('{2'd3, 8'h00, 3'd2, 1'b1});
    plan.push_back('{2'd1, 8'h3C, 3'd0, 1'b0});
    plan.push_back('{2'd2, 8'hA5, 3'd5, 1'b1});
    plan.push_back('{2'd2, 8'h11, 3'd1, 1'b0});
    plan.push_back('{2'd2, 8'h22, 3'd1, 1'b1});
    plan.push_back('{2'd0, 8'h90, 3'd4, 1'b0});
    for (int i = 0; i < 70; i++) run_cycle();
    directed = 0;

    for (int i = 0; i < 1500; i++) run_cycle();

    // reset in the middle of a read strobe
    quiet = 1;
    for (int i = 0; i < 40; i++) run_cycle();
    plan.push_back('{2'd3, 8'h00, 3'd3, 1'b1});
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      check_cycle();
      if (active && cur.op == 2'd3 &&
          cyc - t0 == TCS + 1) begin
        hit = 1;
      end else begin
        drive();
        step();
      end
    end
    check_eq("rd_low_reached", hit, 1);
    bus.req_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    release_reset();
    quiet = 0;
    for (int i = 0; i < 300; i++) run_cycle();

    bus.req_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
